// File: rtl/ac_scan_sequencer_if.sv
// Character/config/result bundle between the character source and the
// Aho-Corasick scan sequencer.
interface ac_scan_sequencer_if #(
  parameter int STATE_W = 8,
  parameter int CHAR_W  = 4,
  parameter int CNT_W   = 16
);
  logic               INITIALIZE;
  logic               CHAR_VALID;
  logic               CHAR_READY;
  logic [CHAR_W-1:0]  STRING;
  logic               CFG_WE;
  logic               CFG_READY;
  logic [2:0]         CFG_SEL;
  logic [4:0]         CFG_ADDR;
  logic [STATE_W-1:0] CFG_DATA;
  logic [STATE_W-1:0] NOW_STATE_OUT;
  logic               RESULT_VALID;
  logic               EN_MATCH;
  logic [CNT_W-1:0]   MATCH_COUNT;
  logic               ERR;

  // Character source / configuration side
  modport master (
    output INITIALIZE, CHAR_VALID, STRING, CFG_WE, CFG_SEL, CFG_ADDR, CFG_DATA,
    input  CHAR_READY, CFG_READY, NOW_STATE_OUT, RESULT_VALID, EN_MATCH,
           MATCH_COUNT, ERR
  );

  // Sequencer side
  modport slave (
    input  INITIALIZE, CHAR_VALID, STRING, CFG_WE, CFG_SEL, CFG_ADDR, CFG_DATA,
    output CHAR_READY, CFG_READY, NOW_STATE_OUT, RESULT_VALID, EN_MATCH,
           MATCH_COUNT, ERR
  );
endinterface

// File: rtl/ac_scan_sequencer.sv
// Aho-Corasick scan sequencer: walks the goto table one entry per cycle,
// follows failure links on a miss, and reports the new state and match flag.
module ac_scan_sequencer #(
  parameter int ENTRIES = 32,
  parameter int STATE_W = 8,
  parameter int CHAR_W  = 4,
  parameter int CNT_W   = 16
) (
  input logic                CLK,
  input logic                RST,
  ac_scan_sequencer_if.slave bus
);
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int CNTE_W  = $clog2(ENTRIES + 1);

  localparam logic [CNTE_W-1:0]  ONE_E     = CNTE_W'(1);
  localparam logic [CNTE_W-1:0]  ENTRIES_E = CNTE_W'(ENTRIES);
  localparam logic [STATE_W-1:0] ENTRIES_S = STATE_W'(ENTRIES);
  localparam logic [STATE_W-1:0] ONE_S     = STATE_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Table storage (goto/failure contents are intentionally not reset)
  logic [STATE_W-1:0] r_cur  [ENTRIES];
  logic [CHAR_W-1:0]  r_chr  [ENTRIES];
  logic [STATE_W-1:0] r_nxt  [ENTRIES];
  logic [STATE_W-1:0] r_fail [ENTRIES];
  logic [ENTRIES-1:0] r_flag;
  logic [CNTE_W-1:0]  r_count;

  // Sequencer state
  logic [1:0]         r_state;
  logic [CHAR_W-1:0]  r_char;
  logic [STATE_W-1:0] r_scan_state;
  logic [IDX_W-1:0]   r_idx;
  logic [CNTE_W-1:0]  r_hops;
  logic [STATE_W-1:0] r_now_state;
  logic               r_rv;
  logic               r_en;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_cfg_we;
  logic               w_addr_ok;
  logic [IDX_W-1:0]   w_cfg_idx;
  logic [5:0]         w_cfg_cnt_raw;
  logic [CNTE_W-1:0]  w_idx_next;
  logic               w_hit;
  logic               w_last;
  logic               w_state_oor;
  logic [IDX_W-1:0]   w_fidx;
  logic               w_flag_hit;
  logic [IDX_W-1:0]   w_flag_idx;

  assign w_cfg_we      = bus.CFG_WE && (r_state == S_IDLE);
  assign w_addr_ok     = int'(bus.CFG_ADDR) < ENTRIES;
  assign w_cfg_idx     = IDX_W'(bus.CFG_ADDR);
  assign w_cfg_cnt_raw = bus.CFG_DATA[5:0];

  // Entry compare and scan/fail bookkeeping
  always_comb begin
    w_idx_next  = CNTE_W'(r_idx) + ONE_E;
    w_hit       = (r_count != '0) &&
                  (r_cur[r_idx] == r_scan_state) && (r_chr[r_idx] == r_char);
    w_last      = (r_count == '0) || (w_idx_next >= r_count);
    w_state_oor = r_scan_state > ENTRIES_S;
    w_fidx      = IDX_W'(r_scan_state - ONE_S);
    w_flag_idx  = IDX_W'(r_now_state - ONE_S);
    w_flag_hit  = (r_now_state != '0) && (r_now_state <= ENTRIES_S) &&
                  r_flag[w_flag_idx];
  end

  // Goto/failure table writes, accepted only while idle
  always_ff @(posedge CLK) begin
    if (w_cfg_we && w_addr_ok) begin
      case (bus.CFG_SEL)
        3'd0:    r_cur[w_cfg_idx]  <= bus.CFG_DATA;
        3'd1:    r_chr[w_cfg_idx]  <= bus.CFG_DATA[CHAR_W-1:0];
        3'd2:    r_nxt[w_cfg_idx]  <= bus.CFG_DATA;
        3'd3:    r_fail[w_cfg_idx] <= bus.CFG_DATA;
        default: ;
      endcase
    end
  end

  // Entry count (clamped to ENTRIES) and output flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
      r_flag  <= '0;
    end else if (w_cfg_we) begin
      if (bus.CFG_SEL == 3'd4)
        r_count <= (w_cfg_cnt_raw > 6'(ENTRIES)) ? ENTRIES_E : CNTE_W'(w_cfg_cnt_raw);
      else if (bus.CFG_SEL == 3'd5 && w_addr_ok)
        r_flag[w_cfg_idx] <= bus.CFG_DATA[0];
    end
  end

  // Sequencer FSM: IDLE -> SCAN (<-> FAIL) -> DONE -> IDLE
  always_ff @(posedge CLK) begin
    if (RST || bus.INITIALIZE) begin
      r_state      <= S_IDLE;
      r_char       <= '0;
      r_scan_state <= '0;
      r_idx        <= '0;
      r_hops       <= '0;
      r_now_state  <= '0;
      r_rv         <= 1'b0;
      r_en         <= 1'b0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_rv <= 1'b0;
      r_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.CHAR_VALID) begin
            r_char       <= bus.STRING;
            r_scan_state <= r_now_state;
            r_idx        <= '0;
            r_hops       <= '0;
            r_state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_now_state <= r_nxt[r_idx];
            r_state     <= S_DONE;
          end else if (!w_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end else if (r_scan_state == '0) begin
            r_now_state <= '0;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_FAIL;
          end
        end
        S_FAIL: begin
          // Out-of-range state or exhausted hop budget ends the search at root
          if (w_state_oor || (r_hops + ONE_E == ENTRIES_E)) begin
            r_err       <= 1'b1;
            r_now_state <= '0;
            r_state     <= S_DONE;
          end else begin
            r_scan_state <= r_fail[w_fidx];
            r_idx        <= '0;
            r_hops       <= r_hops + ONE_E;
            r_state      <= S_SCAN;
          end
        end
        default: begin
          r_rv    <= 1'b1;
          r_en    <= w_flag_hit;
          if (w_flag_hit && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.CHAR_READY    = (r_state == S_IDLE);
  assign bus.CFG_READY     = (r_state == S_IDLE);
  assign bus.NOW_STATE_OUT = r_now_state;
  assign bus.RESULT_VALID  = r_rv;
  assign bus.EN_MATCH      = r_en;
  assign bus.MATCH_COUNT   = r_cnt;
  assign bus.ERR           = r_err;
endmodule

// File: tb/tb_ac_scan_sequencer.sv
// Self-checking bench for ac_scan_sequencer: directed table scenarios plus
// randomized tables/characters compared against a behavioural model.
module tb_ac_scan_sequencer;
  localparam int ENTRIES = 32;
  localparam int STATE_W = 8;
  localparam int CHAR_W  = 4;
  localparam int CNT_W   = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ac_scan_sequencer_if #(.STATE_W(STATE_W), .CHAR_W(CHAR_W), .CNT_W(CNT_W)) bus ();

  ac_scan_sequencer #(.ENTRIES(ENTRIES), .STATE_W(STATE_W), .CHAR_W(CHAR_W), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural model of the tables and visible state
  int m_cur [ENTRIES];
  int m_chr [ENTRIES];
  int m_nxt [ENTRIES];
  int m_fail[ENTRIES];
  bit m_flag[ENTRIES];
  int m_count;
  int m_state;
  int m_cnt;
  bit m_err;

  // Outstanding character expectation
  bit pend = 1'b0;
  bit chk_en = 1'b0;
  int exp_rv, exp_state, exp_cnt;
  bit exp_en, exp_err;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Full search for one character: returns new state, error flag and the
  // number of cycles from the accept edge to the RESULT_VALID edge.
  function automatic void model_char(input int c, input int s0,
                                     output int nxt, output bit err, output int lat);
    int s = s0;
    int hops = 0;
    bit done = 0;
    lat = 0; err = 0; nxt = 0;
    while (!done) begin
      int k = -1;
      for (int i = 0; i < m_count; i++)
        if (k < 0 && m_cur[i] == s && m_chr[i] == c) k = i;
      if (k >= 0) begin
        lat += k + 1; nxt = m_nxt[k]; done = 1;
      end else begin
        lat += (m_count == 0) ? 1 : m_count;
        if (s == 0) begin
          nxt = 0; done = 1;
        end else begin
          lat += 1;
          if (s > ENTRIES || hops + 1 == ENTRIES) begin
            err = 1; nxt = 0; done = 1;
          end else begin
            s = m_fail[s-1]; hops++;
          end
        end
      end
    end
    lat += 1;
  endfunction

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      if (pend) begin
        check("result_valid", bus.RESULT_VALID, cyc == exp_rv);
        check("char_ready_busy", bus.CHAR_READY, cyc >= exp_rv);
        check("cfg_ready_busy", bus.CFG_READY, cyc >= exp_rv);
        if (cyc == exp_rv) begin
          check("now_state", bus.NOW_STATE_OUT, exp_state);
          check("en_match", bus.EN_MATCH, exp_en);
          check("match_count", bus.MATCH_COUNT, exp_cnt);
          check("err", bus.ERR, exp_err);
        end
      end else begin
        check("idle_result_valid", bus.RESULT_VALID, 0);
        check("idle_char_ready", bus.CHAR_READY, 1);
        check("idle_now_state", bus.NOW_STATE_OUT, m_state);
        check("idle_match_count", bus.MATCH_COUNT, m_cnt);
        check("idle_err", bus.ERR, m_err);
      end
    end
  end

  task automatic cfg(input int sel, input int addr, input int data);
    bus.CFG_WE = 1'b1; bus.CFG_SEL = 3'(sel); bus.CFG_ADDR = 5'(addr); bus.CFG_DATA = 8'(data);
    @(posedge CLK); #1;
    bus.CFG_WE = 1'b0;
    case (sel)
      0: m_cur[addr]  = data;
      1: m_chr[addr]  = data & 15;
      2: m_nxt[addr]  = data;
      3: m_fail[addr] = data;
      4: m_count      = ((data & 63) > ENTRIES) ? ENTRIES : (data & 63);
      5: m_flag[addr] = data[0];
      default: ;
    endcase
  endtask

  task automatic send(input int c, output int o_state, output bit o_en,
                      output bit o_err, output int o_lat);
    int n, l;
    bit e;
    bus.CHAR_VALID = 1'b1; bus.STRING = 4'(c);
    @(posedge CLK); #1;
    bus.CHAR_VALID = 1'b0;
    model_char(c, m_state, n, e, l);
    exp_state = n;
    exp_err   = m_err | e;
    exp_en    = (n >= 1 && n <= ENTRIES) ? m_flag[n-1] : 1'b0;
    exp_cnt   = (exp_en && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    exp_rv    = cyc + l;
    pend      = 1'b1;
    while (cyc < exp_rv) begin @(posedge CLK); #1; end
    @(negedge CLK); #1;
    m_state = exp_state; m_err = exp_err; m_cnt = exp_cnt;
    pend = 1'b0;
    o_state = n; o_en = exp_en; o_err = e; o_lat = l;
  endtask

  task automatic init_pulse();
    bus.INITIALIZE = 1'b1;
    @(posedge CLK); #1;
    bus.INITIALIZE = 1'b0;
    m_state = 0; m_cnt = 0; m_err = 0;
  endtask

  int cfg_tab[19][3] = '{
    '{4,0,4},
    '{0,0,0}, '{1,0,1}, '{2,0,1},
    '{0,1,1}, '{1,1,2}, '{2,1,2},
    '{0,2,0}, '{1,2,2}, '{2,2,3},
    '{0,3,3}, '{1,3,3}, '{2,3,4},
    '{3,0,0}, '{3,1,3}, '{3,2,0}, '{3,3,0},
    '{5,1,1}, '{5,3,1}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, lat, rv_seen;
    bit en, er;
    bus.INITIALIZE = 0; bus.CHAR_VALID = 0; bus.STRING = '0;
    bus.CFG_WE = 0; bus.CFG_SEL = '0; bus.CFG_ADDR = '0; bus.CFG_DATA = '0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_now_state", bus.NOW_STATE_OUT, 0);
    check("rst_result_valid", bus.RESULT_VALID, 0);
    check("rst_en_match", bus.EN_MATCH, 0);
    check("rst_match_count", bus.MATCH_COUNT, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_char_ready", bus.CHAR_READY, 1);
    check("rst_cfg_ready", bus.CFG_READY, 1);
    #1;
    for (int i = 0; i < ENTRIES; i++) begin
      m_cur[i] = 0; m_chr[i] = 0; m_nxt[i] = 0; m_fail[i] = 0; m_flag[i] = 0;
    end
    m_count = 0; m_state = 0; m_cnt = 0; m_err = 0;
    chk_en = 1'b1;

    // Empty goto table after reset: immediate root miss
    send(5, st, en, er, lat);
    check("pin_count0_lat", lat, 2);
    check("pin_count0_state", st, 0);

    for (int i = 0; i < 19; i++) cfg(cfg_tab[i][0], cfg_tab[i][1], cfg_tab[i][2]);

    send(1, st, en, er, lat);
    check("pin_c1_lat", lat, 2);  check("pin_c1_state", st, 1);  check("pin_c1_en", en, 0);
    send(2, st, en, er, lat);
    check("pin_c2_lat", lat, 3);  check("pin_c2_state", st, 2);  check("pin_c2_en", en, 1);
    check("pin_c2_cnt", m_cnt, 1);
    send(3, st, en, er, lat);
    check("pin_c3_lat", lat, 10); check("pin_c3_state", st, 4);  check("pin_c3_en", en, 1);
    check("pin_c3_cnt", m_cnt, 2);
    send(5, st, en, er, lat);
    check("pin_back_to_root", st, 0);
    send(5, st, en, er, lat);
    check("pin_rootmiss_lat", lat, 5); check("pin_rootmiss_state", st, 0);
    check("pin_rootmiss_err", er, 0);

    // Failure loop s1 <-> s2
    cfg(3, 0, 2); cfg(3, 1, 1);
    send(1, st, en, er, lat);
    check("pin_loop_pre_state", st, 1);
    send(7, st, en, er, lat);
    check("pin_loop_err", er, 1); check("pin_loop_state", st, 0);

    // INITIALIZE mid-scan with an ignored config write
    chk_en = 1'b0;
    bus.CHAR_VALID = 1'b1; bus.STRING = 4'd5;
    @(posedge CLK); #1;
    bus.CHAR_VALID = 1'b0;
    bus.CFG_WE = 1'b1; bus.CFG_SEL = 3'd0; bus.CFG_ADDR = 5'd0; bus.CFG_DATA = 8'd9;
    @(negedge CLK);
    check("scan_cfg_ready", bus.CFG_READY, 0);
    check("scan_char_ready", bus.CHAR_READY, 0);
    @(posedge CLK); #1;
    bus.CFG_WE = 1'b0;
    bus.INITIALIZE = 1'b1;
    @(posedge CLK); #1;
    bus.INITIALIZE = 1'b0;
    check("init_char_ready", bus.CHAR_READY, 1);
    check("init_now_state", bus.NOW_STATE_OUT, 0);
    check("init_match_count", bus.MATCH_COUNT, 0);
    check("init_err", bus.ERR, 0);
    rv_seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.RESULT_VALID) rv_seen++;
    end
    check("init_no_result", rv_seen, 0);
    #1;
    m_state = 0; m_cnt = 0; m_err = 0;
    chk_en = 1'b1;
    send(1, st, en, er, lat);
    check("pin_table_kept_state", st, 1);

    // Randomized tables and characters
    for (int r = 0; r < 6; r++) begin
      int ne;
      ne = (r == 0) ? ENTRIES : 10;
      cfg(4, 0, (r == 0) ? 50 : int'($urandom_range(0, 10)));
      for (int i = 0; i < ne; i++) begin
        cfg(0, i, $urandom_range(0, 6));
        cfg(1, i, $urandom_range(0, 3));
        cfg(2, i, ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 6)));
      end
      for (int i = 0; i < 6; i++) begin
        cfg(3, i, (r == 0) ? 0 : (($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 6))));
        cfg(5, i, $urandom_range(0, 1));
      end
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 15) == 0) init_pulse();
        send(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)),
             st, en, er, lat);
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
